// File: rtl/vram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter_if
// Brief    : Display, CPU and VRAM-side signal bundle for the VRAM arbiter.
// Revision : 1.0
// ============================================================================
interface vram_arbiter_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16,
    parameter int WAIT_W = 16
);
    logic              disp_active;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    logic              err_overrun;
    logic [WAIT_W-1:0] cpu_wait_max;

    modport slave (
        input  disp_active, disp_req, disp_addr,
        output disp_data, disp_valid,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata,
        output err_overrun, cpu_wait_max
    );

    modport master (
        output disp_active, disp_req, disp_addr,
        input  disp_data, disp_valid,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata,
        input  err_overrun, cpu_wait_max
    );
endinterface
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Brief    : Single-port VRAM arbiter; display reads have strict priority and
//            fixed 3-cycle latency, the CPU req/ack port takes free slots.
// Revision : 1.0
// ============================================================================
module vram_arbiter #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16,
    parameter int WAIT_W = 16
) (
    input  logic                 CLK,
    input  logic                 RST_BTN,
    vram_arbiter_if.slave        bus
);
    typedef enum logic [2:0] {
        C_IDLE = 3'd0,
        C_WR   = 3'd1,
        C_RD1  = 3'd2,
        C_RD2  = 3'd3,
        C_ACK  = 3'd4
    } cpu_state_t;

    cpu_state_t        r_state;
    cpu_state_t        w_state_next;
    logic              w_cpu_ack;

    logic              w_disp_acc;
    logic              w_cpu_grant;
    logic              w_cpu_waiting;

    logic [2:0]        r_disp_pipe;
    logic [DATA_W-1:0] r_disp_data;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_we;
    logic              r_err_overrun;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_next;
    logic [WAIT_W-1:0] r_wait_max;

    assign w_disp_acc    = bus.disp_req & bus.disp_active;
    assign w_cpu_grant   = ~w_disp_acc & bus.cpu_req & (r_state == C_IDLE);
    assign w_cpu_waiting = w_disp_acc & bus.cpu_req & (r_state == C_IDLE);

    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cpu_ack    = 1'b0;
        case (r_state)
            C_IDLE: begin
                if (w_cpu_grant) begin
                    w_state_next = bus.cpu_we ? C_WR : C_RD1;
                end
            end
            C_WR: begin
                w_cpu_ack    = 1'b1;
                w_state_next = C_IDLE;
            end
            C_RD1:   w_state_next = C_RD2;
            C_RD2:   w_state_next = C_ACK;
            C_ACK: begin
                w_cpu_ack    = 1'b1;
                w_state_next = C_IDLE;
            end
            default: w_state_next = C_IDLE;
        endcase
    end

    // One request per cycle into the VRAM: display first, then CPU, else idle.
    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
        end else if (w_disp_acc) begin
            r_mem_addr  <= bus.disp_addr;
            r_mem_we    <= 1'b0;
        end else if (w_cpu_grant) begin
            r_mem_addr  <= bus.cpu_addr;
            r_mem_wdata <= bus.cpu_wdata;
            r_mem_we    <= bus.cpu_we;
        end else begin
            r_mem_we    <= 1'b0;
        end
    end

    // Stage 0: address out, stage 1: VRAM data returns, stage 2: data presented.
    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            r_disp_pipe   <= '0;
            r_disp_data   <= '0;
            r_cpu_rdata   <= '0;
            r_err_overrun <= 1'b0;
        end else begin
            r_disp_pipe <= {r_disp_pipe[1:0], w_disp_acc};
            if (r_disp_pipe[1]) begin
                r_disp_data <= bus.mem_rdata;
            end
            if (r_state == C_RD2) begin
                r_cpu_rdata <= bus.mem_rdata;
            end
            if (w_disp_acc && r_disp_pipe[0]) begin
                r_err_overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        w_wait_next = r_wait_cnt;
        if (w_cpu_grant) begin
            w_wait_next = '0;
        end else if (w_cpu_waiting && !(&r_wait_cnt)) begin
            w_wait_next = r_wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            r_wait_cnt <= '0;
            r_wait_max <= '0;
        end else begin
            r_wait_cnt <= w_wait_next;
            if (w_wait_next > r_wait_max) begin
                r_wait_max <= w_wait_next;
            end
        end
    end

    assign bus.disp_valid   = r_disp_pipe[2];
    assign bus.disp_data    = r_disp_data;
    assign bus.cpu_ack      = w_cpu_ack;
    assign bus.cpu_rdata    = r_cpu_rdata;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_wdata    = r_mem_wdata;
    assign bus.mem_we       = r_mem_we;
    assign bus.err_overrun  = r_err_overrun;
    assign bus.cpu_wait_max = r_wait_max;
endmodule
`default_nettype wire
